// File: rtl/ro_freq_meter.sv
// ---------------------------------------------------------------------------
// ro_freq_meter
//   Frequency meter for the NAND ring-oscillator stage. It enables the
//   oscillator, lets it settle, then counts its rising edges over a fixed
//   window of clk cycles. The count is reported as the frequency measure,
//   with a start/done handshake toward the controlling logic.
//
// Ports
//   clk       in            system clock, rising edge
//   reset_n   in            asynchronous active-low reset
//   start     in            request a measurement (sampled only when idle)
//   abort     in            cancel a measurement in progress
//   osc_in    in            oscillator output, asynchronous to clk
//   osc_en    out           oscillator enable
//   busy      out           high while settling or measuring
//   done      out           one-cycle pulse when result is updated
//   valid     out           result holds a completed measurement
//   overflow  out           edge count saturated in the last measurement
//   result    out [CNT_W]   rising-edge count of the last completed window
//
// Counting is only exact while the oscillator period exceeds two clk
// periods; faster oscillators alias and this is not flagged.
// ---------------------------------------------------------------------------
module ro_freq_meter #(
    parameter int CNT_W         = 16,
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             osc_in,
    output logic             osc_en,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             overflow,
    output logic [CNT_W-1:0] result
);

    // One timer serves both the settle and the gate phases.
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                 state_r,  state_nxt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   osc_sync_s;
    logic                   rise_s;
    logic [TMR_W-1:0]       timer_r,  timer_nxt_s;
    logic [CNT_W-1:0]       count_r,  count_nxt_s;
    logic [CNT_W-1:0]       result_r, result_nxt_s;
    logic                   osc_en_r, osc_en_nxt_s;
    logic                   busy_r,   busy_nxt_s;
    logic                   done_r,   done_nxt_s;
    logic                   valid_r,  valid_nxt_s;
    logic                   ovf_r,    ovf_nxt_s;

    assign osc_sync_s = sync_r[SYNC_STAGES-1];
    // A rising edge is a 0 -> 1 step between the synchronised sample and its history.
    assign rise_s     = osc_sync_s & ~hist_r;

    // Synchroniser chain and edge history run in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], osc_in};
            hist_r <= osc_sync_s;
        end
    end

    // Next-state and next-output logic of the measurement sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        timer_nxt_s  = timer_r;
        count_nxt_s  = count_r;
        result_nxt_s = result_r;
        osc_en_nxt_s = osc_en_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        valid_nxt_s  = valid_r;
        ovf_nxt_s    = ovf_r;

        case (state_r)
            ST_IDLE: begin
                // start together with abort is treated as no request.
                if (start && !abort) begin
                    state_nxt_s  = ST_SETTLE;
                    osc_en_nxt_s = 1'b1;
                    busy_nxt_s   = 1'b1;
                    valid_nxt_s  = 1'b0;
                    ovf_nxt_s    = 1'b0;
                    timer_nxt_s  = {TMR_W{1'b0}};
                    count_nxt_s  = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nxt_s  = ST_IDLE;
                    osc_en_nxt_s = 1'b0;
                    busy_nxt_s   = 1'b0;
                end else if (timer_r == SETTLE_LAST) begin
                    state_nxt_s = ST_MEASURE;
                    timer_nxt_s = {TMR_W{1'b0}};
                end else begin
                    timer_nxt_s = timer_r + TMR_W'(1'b1);
                end
            end
            ST_MEASURE: begin
                if (abort) begin
                    state_nxt_s  = ST_IDLE;
                    osc_en_nxt_s = 1'b0;
                    busy_nxt_s   = 1'b0;
                end else begin
                    // Saturate rather than wrap; flag the lost edge.
                    if (rise_s) begin
                        if (count_r == CNT_MAX) begin
                            ovf_nxt_s = 1'b1;
                        end else begin
                            count_nxt_s = count_r + CNT_W'(1'b1);
                        end
                    end else begin
                        count_nxt_s = count_r;
                    end
                    if (timer_r == GATE_LAST) begin
                        state_nxt_s  = ST_DONE;
                        osc_en_nxt_s = 1'b0;
                        busy_nxt_s   = 1'b0;
                    end else begin
                        timer_nxt_s = timer_r + TMR_W'(1'b1);
                    end
                end
            end
            ST_DONE: begin
                // Count already includes any edge from the final gate cycle.
                result_nxt_s = count_r;
                valid_nxt_s  = 1'b1;
                done_nxt_s   = 1'b1;
                state_nxt_s  = ST_IDLE;
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                osc_en_nxt_s = 1'b0;
                busy_nxt_s   = 1'b0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered outputs; reset drops osc_en immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_r  <= {TMR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            result_r <= {CNT_W{1'b0}};
            osc_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            timer_r  <= timer_nxt_s;
            count_r  <= count_nxt_s;
            result_r <= result_nxt_s;
            osc_en_r <= osc_en_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            valid_r  <= valid_nxt_s;
            ovf_r    <= ovf_nxt_s;
        end
    end

    assign osc_en   = osc_en_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign valid    = valid_r;
    assign overflow = ovf_r;
    assign result   = result_r;

endmodule

// File: tb/tb_ro_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_ro_freq_meter
//   Two meters: a 16-bit one for nominal, abort, handshake and reset
//   behaviour, and a 4-bit one that saturates. Oscillators are free-running
//   square waves gated by each meter's osc_en. Expected results are queued
//   when a measurement is started; monitors pop and compare on every done.
// ---------------------------------------------------------------------------
module tb_ro_freq_meter;

    typedef struct {
        int lo;
        int hi;
        int ovf;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start1, abort1, osc_in1;
    logic        osc_en1, busy1, done1, valid1, ovf1;
    logic [15:0] result1;
    logic        start2, abort2, osc_in2;
    logic        osc_en2, busy2, done2, valid2, ovf2;
    logic [3:0]  result2;
    logic        osc50, osc40, dead;

    int errors = 0;
    int checks = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    exp_t q1[$];
    exp_t q2[$];

    ro_freq_meter #(.CNT_W(16), .GATE_CYCLES(100), .SETTLE_CYCLES(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1), .osc_in(osc_in1),
        .osc_en(osc_en1), .busy(busy1), .done(done1), .valid(valid1),
        .overflow(ovf1), .result(result1)
    );

    ro_freq_meter #(.CNT_W(4), .GATE_CYCLES(100), .SETTLE_CYCLES(8), .SYNC_STAGES(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(start2), .abort(abort2), .osc_in(osc_in2),
        .osc_en(osc_en2), .busy(busy2), .done(done2), .valid(valid2),
        .overflow(ovf2), .result(result2)
    );

    // Oscillators only run while enabled; edges are offset from clk edges.
    assign osc_in1 = osc_en1 & osc50 & ~dead;
    assign osc_in2 = osc_en2 & osc40;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        osc50 = 1'b0;
        #3;
        forever #25 osc50 = ~osc50;
    end

    initial begin
        osc40 = 1'b0;
        #3;
        forever #20 osc40 = ~osc40;
    end

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard monitor for the 16-bit meter.
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            done_cnt1++;
            if (q1.size() == 0) begin
                chk("unexpected_done1", 1, 0, 0);
            end else begin
                e = q1.pop_front();
                chk("result1", int'(result1), e.lo, e.hi);
                chk("overflow1", int'(ovf1), e.ovf, e.ovf);
                chk("valid1", int'(valid1), 1, 1);
            end
        end
    end

    // Scoreboard monitor for the saturating meter.
    always @(negedge clk) begin
        exp_t e;
        if (done2) begin
            done_cnt2++;
            if (q2.size() == 0) begin
                chk("unexpected_done2", 1, 0, 0);
            end else begin
                e = q2.pop_front();
                chk("result2", int'(result2), e.lo, e.hi);
                chk("overflow2", int'(ovf2), e.ovf, e.ovf);
                chk("valid2", int'(valid2), 1, 1);
            end
        end
    end

    // Start one measurement on the 16-bit meter and check its timing.
    task automatic run1(input int lo, input int hi, input int ovf);
        int en_cnt  = 0;
        int done_at = -1;
        exp_t e;
        e.lo = lo; e.hi = hi; e.ovf = ovf;
        q1.push_back(e);
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int n = 1; n <= 300 && done_at < 0; n++) begin
            if (n > 1) @(negedge clk);
            if (osc_en1) en_cnt++;
            if (done1) done_at = n - 1;
        end
        chk("osc_en_cycles", en_cnt, 108, 108);
        chk("done_latency", done_at, 109, 109);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_osc_en"}, int'(osc_en1), 0, 0);
        chk({tag, "_busy"}, int'(busy1), 0, 0);
        chk({tag, "_done"}, int'(done1), 0, 0);
        chk({tag, "_valid"}, int'(valid1), 0, 0);
        chk({tag, "_overflow"}, int'(ovf1), 0, 0);
        chk({tag, "_result"}, int'(result1), 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int seen;
        exp_t e;
        start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0; dead = 1'b0;

        // T1: reset with random inputs
        reset_n = 1'b0;
        #1;
        chk("t1_osc_en_immediate", int'(osc_en1), 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start1 = 1'($urandom_range(0, 1));
            abort1 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk_all_zero("t1");
        start1 = 1'b0; abort1 = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // T2: nominal 50 ns oscillator
        run1(19, 21, 0);

        // T3: saturation on the 4-bit meter
        base = done_cnt2;
        e.lo = 15; e.hi = 15; e.ovf = 1;
        q2.push_back(e);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        seen = 0;
        for (int n = 0; n < 300 && seen == 0; n++) begin
            @(negedge clk);
            if (done2) seen = 1;
        end
        chk("t3_done_seen", seen, 1, 1);
        repeat (5) @(negedge clk);
        chk("t3_done_pulses", done_cnt2 - base, 1, 1);

        // T6a: dead oscillator
        dead = 1'b1;
        run1(0, 0, 0);
        dead = 1'b0;

        // T4: abort at measure cycle 50
        base = done_cnt1;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (57) @(negedge clk);
        chk("t4_busy_before_abort", int'(busy1), 1, 1);
        abort1 = 1'b1;
        @(negedge clk) abort1 = 1'b0;
        chk("t4_osc_en", int'(osc_en1), 0, 0);
        chk("t4_busy", int'(busy1), 0, 0);
        chk("t4_valid", int'(valid1), 0, 0);
        chk("t4_result_kept", int'(result1), 0, 0);
        repeat (130) @(negedge clk);
        chk("t4_no_done", done_cnt1 - base, 0, 0);
        chk("t4_valid_later", int'(valid1), 0, 0);

        // T5: start held through a measurement -> one run per idle entry
        base = done_cnt1;
        e.lo = 19; e.hi = 21; e.ovf = 0;
        q1.push_back(e);
        q1.push_back(e);
        @(negedge clk) start1 = 1'b1;
        repeat (115) @(negedge clk);
        start1 = 1'b0;
        for (int n = 0; n < 300 && (done_cnt1 - base) < 2; n++) begin
            @(negedge clk);
        end
        repeat (130) @(negedge clk);
        chk("t5_held_start_runs", done_cnt1 - base, 2, 2);

        // T5: start and abort together in idle
        @(negedge clk);
        start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk);
        chk("t5_sa_osc_en", int'(osc_en1), 0, 0);
        chk("t5_sa_busy", int'(busy1), 0, 0);
        start1 = 1'b0; abort1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_sa_still_idle", int'(busy1), 0, 0);

        // T6b: reset pulse during measure, then a clean measurement
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (50) @(negedge clk);
        chk("t6_running", int'(osc_en1), 1, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_osc_en_async", int'(osc_en1), 0, 0);
        repeat (3) @(negedge clk);
        chk_all_zero("t6");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run1(19, 21, 0);

        repeat (5) @(negedge clk);
        chk("q1_drained", q1.size(), 0, 0);
        chk("q2_drained", q2.size(), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
